// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin stream arbiter.
package stream_pkg;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Index width; a single requester still gets a 1-bit index.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Bundle of the N producer streams and the single merged output stream.
interface stream_rr_arbiter_if #(
    parameter int num_inputs = 4,
    parameter int data_size  = 32
);
    import stream_pkg::*;

    localparam int IDX_W = idx_w(num_inputs);

    logic [num_inputs*data_size-1:0] in_data;
    logic [num_inputs-1:0]           in_last;
    logic [num_inputs-1:0]           in_valid;
    logic [num_inputs-1:0]           in_ready;
    logic [data_size-1:0]            out_data;
    logic                            out_last;
    logic [IDX_W-1:0]                out_index;
    logic                            out_valid;
    logic                            out_ready;

    modport slave (
        input  in_data, in_last, in_valid, out_ready,
        output in_ready, out_data, out_last, out_index, out_valid
    );

    modport master (
        output in_data, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_last, out_index, out_valid
    );

endinterface

// File: rtl/stream_rr_arbiter_select.sv
// Combinational round-robin pick: first requester at or after prio, wrapping.
module rr_priority_select #(
    parameter int num_inputs = 4,
    parameter int IDX_W      = 2
) (
    input  logic [num_inputs-1:0] req,
    input  logic [IDX_W-1:0]      prio,
    output logic [IDX_W-1:0]      grant,
    output logic                  any_req
);

    logic [2*num_inputs-1:0] dbl_s;
    logic [2*num_inputs-1:0] masked_s;

    // Mask the doubled vector below prio, then take the lowest surviving bit.
    always_comb begin
        dbl_s    = {req, req};
        masked_s = '0;
        grant    = '0;
        for (int j = 0; j < 2*num_inputs; j++) begin
            masked_s[j] = dbl_s[j] & (j >= int'(prio));
        end
        for (int j = 2*num_inputs-1; j >= 0; j--) begin
            grant = masked_s[j] ? ((j >= num_inputs) ? IDX_W'(j - num_inputs) : IDX_W'(j))
                                : grant;
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/stream_rr_arbiter.sv
// N-to-1 round-robin stream arbiter with grant hold under backpressure and
// optional packet lock; zero-latency forward path into a fifo enq port.
module stream_rr_arbiter
    import stream_pkg::*;
#(
    parameter int num_inputs     = 4,
    parameter int data_size      = 32,
    parameter int lock_on_packet = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    stream_rr_arbiter_if.slave  bus
);

    localparam int               IDX_W    = idx_w(num_inputs);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(num_inputs - 1);

    if (num_inputs < 1) begin : g_param_check
        $fatal(1, "stream_rr_arbiter: num_inputs must be >= 1");
    end

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? IDX_W'(0) : i + IDX_W'(1);
    endfunction

    arb_state_e       state_r, state_n_s;
    logic [IDX_W-1:0] prio_r, prio_n_s;
    logic [IDX_W-1:0] grant_q_r, grant_q_n_s;
    logic             pending_r, pending_n_s;

    logic [IDX_W-1:0] rr_grant_s;
    logic             rr_any_s;
    logic             use_q_s;
    logic [IDX_W-1:0] grant_s;
    logic             out_valid_s;
    logic             out_last_s;
    logic             hs_s;

    rr_priority_select #(
        .num_inputs (num_inputs),
        .IDX_W      (IDX_W)
    ) u_select (
        .req     (bus.in_valid),
        .prio    (prio_r),
        .grant   (rr_grant_s),
        .any_req (rr_any_s)
    );

    // Grant source: held/locked index, otherwise a fresh round-robin pick.
    always_comb begin
        use_q_s     = (state_r == LOCKED) || pending_r;
        grant_s     = use_q_s ? grant_q_r : rr_grant_s;
        out_valid_s = ~flush & (use_q_s ? bus.in_valid[grant_s] : rr_any_s);
        out_last_s  = out_valid_s & bus.in_last[grant_s];
        hs_s        = out_valid_s & bus.out_ready;
    end

    // Output mux; everything reads as zero while nothing is offered.
    always_comb begin
        bus.out_valid = out_valid_s;
        bus.out_last  = out_last_s;
        bus.out_index = out_valid_s ? grant_s : IDX_W'(0);
        bus.out_data  = out_valid_s ? bus.in_data[int'(grant_s)*data_size +: data_size]
                                    : {data_size{1'b0}};
        for (int i = 0; i < num_inputs; i++) begin
            bus.in_ready[i] = hs_s & (grant_s == IDX_W'(i));
        end
    end

    // Next-state: flush abort, grant hold while stalled, lock/rotate on transfer.
    always_comb begin
        state_n_s   = state_r;
        prio_n_s    = prio_r;
        grant_q_n_s = grant_q_r;
        pending_n_s = pending_r;
        if (flush) begin
            state_n_s   = ARB;
            prio_n_s    = IDX_W'(0);
            grant_q_n_s = IDX_W'(0);
            pending_n_s = 1'b0;
        end else if (out_valid_s && !bus.out_ready) begin
            pending_n_s = 1'b1;
            grant_q_n_s = grant_s;
        end else if (hs_s) begin
            pending_n_s = 1'b0;
            case (state_r)
                ARB: begin
                    if ((lock_on_packet != 0) && !out_last_s) begin
                        state_n_s   = LOCKED;
                        grant_q_n_s = grant_s;
                    end else begin
                        prio_n_s = next_idx(grant_s);
                    end
                end
                LOCKED: begin
                    if (out_last_s) begin
                        state_n_s = ARB;
                        prio_n_s  = next_idx(grant_q_r);
                    end else begin
                        state_n_s = LOCKED;
                    end
                end
                default: state_n_s = ARB;
            endcase
        end else begin
            pending_n_s = pending_r;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ARB;
            prio_r    <= IDX_W'(0);
            grant_q_r <= IDX_W'(0);
            pending_r <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            prio_r    <= prio_n_s;
            grant_q_r <= grant_q_n_s;
            pending_r <= pending_n_s;
        end
    end

endmodule
